ldpc_iter_ctrl: RTL
===================

Name: ldpc_iter_ctrl

Overview:
Sequencer for the LDPC decoder's array of data cells (LLR/message registers). It drives the one-hot phase bus fsm, the per-cell load strobe and the 3-way variable-to-check edge select vtc_en. It runs one frame through load -> check-node -> variable-node update, iterating until the syndrome passes or the iteration limit is reached. It sits between the frame input interface and the cell array plus syndrome checker.

Parameters:
N_CELLS, 16, number of data cells loaded per frame
ADDR_WID, 4, width of load address, ceil(log2(N_CELLS))
ITER_WID, 5, width of iteration counter and max_iter
CN_CYC, 2, cycles spent in check-node phase per iteration

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  begin a frame; sampled only in IDLE
llr_valid  in  1  input LLR present this cycle
llr_ready  out  1  controller accepts LLR this cycle (LOAD and not full)
max_iter  in  ITER_WID  iteration limit, sampled on start; 0 treated as 1
synd_ok  in  1  syndrome checker result, valid in SYND
fsm  out  4  one-hot phase: [0] IDLE, [1] LOAD, [2] VN update, [3] CN update
sin  out  1  load strobe to cell at load_addr (= llr_valid & llr_ready)
load_addr  out  ADDR_WID  cell index for current LLR
vtc_en  out  3  one-hot edge select during VN phase
iter_cnt  out  ITER_WID  completed iterations of current/last frame
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse at frame end
converged  out  1  frame ended on synd_ok; held until next start

Behaviour:
- Reset (async, active-high): state IDLE, fsm=4'b0001, vtc_en=0, load_addr=0, iter_cnt=0, sin=0, llr_ready=0, busy=0, done=0, converged=0.
- States: IDLE, LOAD, CN, VN, SYND, DONE. fsm is 0001 in IDLE/SYND/DONE, 0010 in LOAD, 1000 in CN, 0100 in VN; exactly one bit set at all times.
- IDLE: start=1 -> LOAD next cycle; latch max_iter (0 -> 1), clear iter_cnt, load_addr and converged.
- LOAD: llr_ready=1. Each cycle with llr_valid: sin=1, then load_addr increments. When the beat at load_addr=N_CELLS-1 is accepted, go to CN and return load_addr to 0. Gaps in llr_valid stall LOAD indefinitely.
- CN: exactly CN_CYC cycles, then VN.
- VN: 3 cycles with vtc_en = 001, 010, 100 in order (registered, aligned with fsm[2]). Then SYND, with iter_cnt incremented on the VN exit edge. vtc_en=0 outside VN.
- SYND: 1 cycle evaluating synd_ok and iter_cnt.
  - synd_ok=1 -> DONE with converged=1.
  - Else, iter_cnt==latched max -> DONE with converged=0.
  - Else -> CN.
- DONE: done=1 for one cycle -> IDLE. iter_cnt and converged hold until next start.
- start outside IDLE is ignored. No abort except reset; reset mid-frame returns to IDLE at once with all outputs at reset values.
- Latency for a full run with no llr_valid gaps: start -> done = 1 + N_CELLS + iterations*(CN_CYC+3+1) + 1 cycles.

Optional Feature:
EARLY_TERM_EN.
- Defined: SYND honours synd_ok as above.
- Undefined: synd_ok is ignored and every frame runs exactly the latched max iterations. converged then equals synd_ok sampled in the final SYND cycle, for reporting only.

Decomposition:
- Package ldpc_ctrl_pkg holds:
  - state encoding constants: IDLE, LOAD, CN, VN, SYND, DONE
  - fsm one-hot bit constants: FSM_IDLE=0, FSM_LOAD=1, FSM_VN=2, FSM_CN=3
  - vtc_en one-hot constants
- One natural sub-module, ldpc_vtc_seq: a 3-step one-hot rotator with start/last outputs, used for the VN phase.

Test Plan:
1. Reset asserted mid-VN (vtc_en=010) -> next edge: fsm=0001, vtc_en=000, busy=0, iter_cnt=0.
2. N_CELLS=16, start, 16 contiguous llr_valid -> sin high 16 cycles, load_addr 0..15; CN entered the cycle after addr 15 accepted.
3. llr_valid toggling 1,0,1,0 during LOAD -> load_addr advances only on valid beats; 16 strobes total, no extra or missing sin.
4. max_iter=3, synd_ok=0 throughout -> exactly three CN(2)/VN(001,010,100)/SYND cycles; done pulses with iter_cnt=3, converged=0; start->done = 1+16+18+1 = 36 cycles.
5. EARLY_TERM_EN defined, max_iter=5, synd_ok=1 in 2nd SYND -> done with iter_cnt=2, converged=1. Macro undefined -> iter_cnt=5.
6. max_iter=0 -> one iteration run, done with iter_cnt=1. start pulsed while busy -> no effect on state or counters.

Source files
------------

// File: rtl/ldpc_ctrl_pkg.sv
// Shared encodings for the LDPC iteration controller: state names,
// phase-bus bit positions and VN edge-select codes.
package ldpc_ctrl_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, CN, VN, SYND, DONE} state_t;

   localparam int FSM_IDLE = 0;
   localparam int FSM_LOAD = 1;
   localparam int FSM_VN   = 2;
   localparam int FSM_CN   = 3;

   localparam logic [3:0] PH_IDLE = 4'b0001 << FSM_IDLE;
   localparam logic [3:0] PH_LOAD = 4'b0001 << FSM_LOAD;
   localparam logic [3:0] PH_VN   = 4'b0001 << FSM_VN;
   localparam logic [3:0] PH_CN   = 4'b0001 << FSM_CN;

   localparam logic [2:0] VTC_OFF = 3'b000;
   localparam logic [2:0] VTC_E0  = 3'b001;
   localparam logic [2:0] VTC_E1  = 3'b010;
   localparam logic [2:0] VTC_E2  = 3'b100;

endpackage

// File: rtl/ldpc_vtc_seq.sv
// Three-step one-hot rotator driving the variable-to-check edge select
// during the VN phase; start loads the first edge, last flags the third.
module ldpc_vtc_seq
   import ldpc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [2:0] vtc_en,
   output logic       last
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         vtc_en <= VTC_OFF;
      else if (start)
         vtc_en <= VTC_E0;
      else
         vtc_en <= {vtc_en[1:0], 1'b0};
   end

   assign last = (vtc_en == VTC_E2);

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// LDPC decoder frame sequencer: load -> (CN -> VN -> syndrome) iterations.
// Define EARLY_TERM_EN to stop iterating as soon as the syndrome passes.
module ldpc_iter_ctrl
   import ldpc_ctrl_pkg::*;
#(
   parameter int N_CELLS  = 16,
   parameter int ADDR_WID = 4,
   parameter int ITER_WID = 5,
   parameter int CN_CYC   = 2
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                llr_valid,
   output logic                llr_ready,
   input  logic [ITER_WID-1:0] max_iter,
   input  logic                synd_ok,
   output logic [3:0]          fsm,
   output logic                sin,
   output logic [ADDR_WID-1:0] load_addr,
   output logic [2:0]          vtc_en,
   output logic [ITER_WID-1:0] iter_cnt,
   output logic                busy,
   output logic                done,
   output logic                converged
);

   localparam int CNT_W = (CN_CYC > 1) ? $clog2(CN_CYC) : 1;
   localparam logic [CNT_W-1:0]    CN_LAST   = CNT_W'(CN_CYC - 1);
   localparam logic [ADDR_WID-1:0] ADDR_LAST = ADDR_WID'(N_CELLS - 1);

   state_t              state;
   logic [ITER_WID-1:0] max_lat;
   logic [CNT_W-1:0]    cn_cnt;
   logic                vn_go;
   logic                vn_last;

   assign sin   = llr_valid & llr_ready;
   // Kick the rotator on the last CN cycle so vtc_en lines up with fsm[FSM_VN].
   assign vn_go = (state == CN) && (cn_cnt == CN_LAST);

   ldpc_vtc_seq u_vtc_seq (
      .clk    (clk),
      .reset  (reset),
      .start  (vn_go),
      .vtc_en (vtc_en),
      .last   (vn_last)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         fsm       <= PH_IDLE;
         llr_ready <= 1'b0;
         load_addr <= '0;
         iter_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         converged <= 1'b0;
         max_lat   <= '0;
         cn_cnt    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state     <= LOAD;
               fsm       <= PH_LOAD;
               llr_ready <= 1'b1;
               busy      <= 1'b1;
               max_lat   <= (max_iter == '0) ? ITER_WID'(1) : max_iter;
               iter_cnt  <= '0;
               load_addr <= '0;
               converged <= 1'b0;
            end
            LOAD: if (sin) begin
               if (load_addr == ADDR_LAST) begin
                  state     <= CN;
                  fsm       <= PH_CN;
                  llr_ready <= 1'b0;
                  load_addr <= '0;
                  cn_cnt    <= '0;
               end else begin
                  load_addr <= load_addr + 1'b1;
               end
            end
            CN: begin
               if (vn_go) begin
                  state <= VN;
                  fsm   <= PH_VN;
               end else begin
                  cn_cnt <= cn_cnt + 1'b1;
               end
            end
            VN: if (vn_last) begin
               state    <= SYND;
               fsm      <= PH_IDLE;
               iter_cnt <= iter_cnt + 1'b1;
            end
            SYND: begin
`ifdef EARLY_TERM_EN
               if (synd_ok || (iter_cnt == max_lat)) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  converged <= synd_ok;
               end else begin
                  state  <= CN;
                  fsm    <= PH_CN;
                  cn_cnt <= '0;
               end
`else
               // synd_ok only reported here; iteration count alone ends the frame.
               if (iter_cnt == max_lat) begin
                  state     <= DONE;
                  done      <= 1'b1;
                  converged <= synd_ok;
               end else begin
                  state  <= CN;
                  fsm    <= PH_CN;
                  cn_cnt <= '0;
               end
`endif
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               fsm       <= PH_IDLE;
               llr_ready <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
